// File: rtl/matrix_pkg.sv
// Shared widths, ASCII codes, FSM state encoding and decade table for the matrix UART sender.
package matrix_pkg;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_DIM = 5;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CONVERT,
        SEND_DIGIT,
        SEND_SEP,
        SEND_CR,
        SEND_LF,
        DONE
    } state_e;

    // Decade weight for digit position 0 (ten-thousands) .. 4 (units).
    function automatic logic [15:0] pow10(input logic [2:0] place);
        case (place)
            3'd0:    return 16'd10000;
            3'd1:    return 16'd1000;
            3'd2:    return 16'd100;
            3'd3:    return 16'd10;
            default: return 16'd1;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; o_ready rises in the last stop-bit cycle so a new byte can follow with no idle gap.
module uart_tx_byte #(
    parameter int unsigned BIT_CYC = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int unsigned CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    logic             active_q, active_d;
    logic             tx_q;
    logic             ready_q;
    logic [8:0]       sh_q;
    logic [3:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign accept  = i_valid && ready_q;
    assign o_ready = ready_q;
    assign o_tx    = tx_q;

    // Bit index 0 is the start bit, 1..8 data, 9 stop.
    always_comb begin
        active_d = active_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        if (accept) begin
            active_d = 1'b1;
            bit_d    = 4'd0;
            cnt_d    = '0;
        end else if (active_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            sh_q     <= '1;
            bit_q    <= 4'd0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            ready_q  <= !active_d || (bit_d == 4'd9 && cnt_d == CNT_LAST);
            if (accept) begin
                tx_q <= 1'b0;
                sh_q <= {1'b1, i_byte};
            end else if (active_q && cnt_q == CNT_LAST) begin
                if (bit_q == 4'd9) begin
                    tx_q <= 1'b1;
                end else begin
                    tx_q <= sh_q[0];
                    sh_q <= {1'b1, sh_q[8:1]};
                end
            end
        end
    end

endmodule

// File: rtl/matrix_uart_sender.sv
// Reads an m x n matrix row-major from storage and prints it over UART as decimal text, one line per row.
module matrix_uart_sender
    import matrix_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned MAX_DIM  = matrix_pkg::MAX_DIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [DATA_W-1:0] i_m,
    input  logic [DATA_W-1:0] i_n,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_uart_tx,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
    localparam int unsigned DIM_W   = $clog2(MAX_DIM + 1);

    state_e            state_q;
    logic [DIM_W-1:0]  m_q, n_q, row_q, col_q;
    logic [15:0]       val_q;
    logic [2:0]        place_q, ndig_q, sidx_q;
    logic [3:0]        cur_q;
    logic              started_q;
    logic [4:0][3:0]   dig_q;
    logic [7:0]        byte_q;
    logic              valid_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              busy_q, done_q, err_q;
    logic              tx_ready, accept, last_col, last_row, dims_bad;
    logic              unused_rd_hi;

    assign accept       = valid_q && tx_ready;
    assign last_col     = (col_q == n_q - DIM_W'(1));
    assign last_row     = (row_q == m_q - DIM_W'(1));
    assign dims_bad     = (i_m == '0) || (i_m > DATA_W'(MAX_DIM)) ||
                          (i_n == '0) || (i_n > DATA_W'(MAX_DIM));
    assign unused_rd_hi = ^i_rd_data[DATA_W-1:16];

    assign o_rd_addr = rd_addr_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;

    uart_tx_byte #(.BIT_CYC(BIT_CYC)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_valid (valid_q),
        .i_byte  (byte_q),
        .o_ready (tx_ready),
        .o_tx    (o_uart_tx)
    );

    // Next element is fetched and converted while the separator / LF is still on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            n_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            val_q     <= '0;
            place_q   <= '0;
            ndig_q    <= '0;
            sidx_q    <= '0;
            cur_q     <= '0;
            started_q <= 1'b0;
            dig_q     <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start && !done_q) begin
                        if (dims_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            m_q       <= DIM_W'(i_m);
                            n_q       <= DIM_W'(i_n);
                            row_q     <= '0;
                            col_q     <= '0;
                            rd_addr_q <= i_base_addr;
                            busy_q    <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                RD_REQ: state_q <= RD_WAIT;
                RD_WAIT: begin
                    val_q     <= i_rd_data[15:0];
                    place_q   <= '0;
                    cur_q     <= '0;
                    ndig_q    <= '0;
                    sidx_q    <= '0;
                    started_q <= 1'b0;
                    state_q   <= CONVERT;
                end
                CONVERT: begin
                    if (val_q >= pow10(place_q)) begin
                        val_q <= val_q - pow10(place_q);
                        cur_q <= cur_q + 4'd1;
                    end else begin
                        // Leading zeros are dropped; the units digit is always kept.
                        if (cur_q != 4'd0 || started_q || place_q == 3'd4) begin
                            dig_q[ndig_q] <= cur_q;
                            ndig_q        <= ndig_q + 3'd1;
                            started_q     <= 1'b1;
                        end
                        cur_q <= '0;
                        if (place_q == 3'd4) begin
                            state_q <= SEND_DIGIT;
                        end else begin
                            place_q <= place_q + 3'd1;
                        end
                    end
                end
                SEND_DIGIT: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        byte_q  <= ASCII_0 + 8'(dig_q[sidx_q]);
                    end else if (accept) begin
                        if (sidx_q + 3'd1 < ndig_q) begin
                            sidx_q <= sidx_q + 3'd1;
                            byte_q <= ASCII_0 + 8'(dig_q[sidx_q + 3'd1]);
                        end else if (last_col) begin
                            byte_q  <= ASCII_CR;
                            state_q <= SEND_CR;
                        end else begin
                            byte_q  <= ASCII_SP;
                            state_q <= SEND_SEP;
                        end
                    end
                end
                SEND_SEP: begin
                    if (accept) begin
                        valid_q   <= 1'b0;
                        col_q     <= col_q + DIM_W'(1);
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        state_q   <= RD_REQ;
                    end
                end
                SEND_CR: begin
                    if (accept) begin
                        byte_q  <= ASCII_LF;
                        state_q <= SEND_LF;
                    end
                end
                SEND_LF: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        if (last_row) begin
                            state_q <= DONE;
                        end else begin
                            row_q     <= row_q + DIM_W'(1);
                            col_q     <= '0;
                            rd_addr_q <= rd_addr_q + ADDR_W'(1);
                            state_q   <= RD_REQ;
                        end
                    end
                end
                DONE: begin
                    // Serializer reports ready in the final stop-bit cycle of the LF.
                    if (tx_ready) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_uart_sender.sv
// Directed bench: decodes the UART line cycle-accurately and compares against hand-built byte strings.
`timescale 1ns/1ps
module tb_matrix_uart_sender;

    localparam int BC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [8:0]  i_base_addr = '0;
    logic [31:0] i_m = '0;
    logic [31:0] i_n = '0;
    logic [8:0]  o_rd_addr;
    logic [31:0] i_rd_data;
    logic        o_uart_tx, o_busy, o_done, o_err;

    logic [31:0] mem [512];
    int          cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          n_chk = 0;
    int          n_bad = 0;

    int          rx_phase = -1;
    int          rx_start = 0;
    logic [9:0]  rx_samp = '0;
    logic        rx_bad = 1'b0;
    logic [7:0]  rx_q [$];
    int          st_q [$];
    logic        bad_q [$];
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    matrix_uart_sender #(.CLK_FREQ(1000), .BAUD(100), .MAX_DIM(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_m         (i_m),
        .i_n         (i_n),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_uart_tx   (o_uart_tx),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always @(posedge clk) i_rd_data <= mem[o_rd_addr];
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_done) done_cnt++;
        if (o_err) err_cnt++;
    end

    // Line decoder: every bit must hold its value for exactly BC cycles.
    always @(negedge clk) begin
        if (rst) begin
            rx_phase = -1;
        end else begin
            if (rx_phase < 0 && o_uart_tx == 1'b0) begin
                rx_phase = 0;
                rx_start = cyc;
                rx_bad   = 1'b0;
            end
            if (rx_phase >= 0) begin
                if (rx_phase % BC == 0) rx_samp[rx_phase / BC] = o_uart_tx;
                else if (o_uart_tx !== rx_samp[rx_phase / BC]) rx_bad = 1'b1;
                rx_phase++;
                if (rx_phase == 10 * BC) begin
                    rx_q.push_back(rx_samp[8:1]);
                    st_q.push_back(rx_start);
                    bad_q.push_back(rx_bad | ~rx_samp[9]);
                    rx_phase = -1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_add(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic exp_eol();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic run_xfer(input string tag, input logic [8:0] base, input int m, input int n,
                            input bit restart, input logic [8:0] last_addr);
        int w;
        int d0;
        int done_cyc;
        rx_q.delete();
        st_q.delete();
        bad_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = base; i_m = 32'(m); i_n = 32'(n);
        @(posedge clk); #1;
        i_start = 1'b0; i_base_addr = 9'h1AA; i_m = 32'd7; i_n = 32'd0;
        @(negedge clk);
        chk({tag, "_busy_rise"}, 32'(o_busy), 32'd1);
        chk({tag, "_first_addr"}, 32'(o_rd_addr), 32'(base));
        if (restart) begin
            repeat (250) @(posedge clk);
            #1; i_start = 1'b1; i_base_addr = 9'h020; i_m = 32'd1; i_n = 32'd1;
            @(posedge clk); #1; i_start = 1'b0;
        end
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!o_done && w < 6000);
        done_cyc = cyc;
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_busy_fall"}, 32'(o_busy), 32'd0);
        i_start = 1'b1; i_base_addr = 9'h020; i_m = 32'd1; i_n = 32'd1;
        @(posedge clk); #1; i_start = 1'b0;
        @(negedge clk);
        chk({tag, "_start_in_done"}, 32'(o_busy), 32'd0);
        repeat (5) @(negedge clk);
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("%s_byte%0d", tag, k), (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hFFFF, 32'(exp_q[k]));
            if (k < bad_q.size()) chk($sformatf("%s_frame%0d", tag, k), 32'(bad_q[k]), 32'd0);
        end
        for (int k = 1; k < st_q.size(); k++)
            chk($sformatf("%s_gap%0d", tag, k), 32'(st_q[k] - st_q[k-1]), 32'(10 * BC));
        if (st_q.size() > 0)
            chk({tag, "_done_lat"}, 32'(done_cyc - st_q[st_q.size()-1]), 32'(10 * BC));
        chk({tag, "_addr_hold"}, 32'(o_rd_addr), 32'(last_addr));
    endtask

    task automatic run_err(input string tag, input int m, input int n, input int quiet);
        int lows;
        int busys;
        int d0;
        int e0;
        lows = 0; busys = 0; d0 = done_cnt; e0 = err_cnt;
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = 9'h010; i_m = 32'(m); i_n = 32'(n);
        @(posedge clk); #1; i_start = 1'b0;
        @(negedge clk);
        chk({tag, "_err_pulse"}, 32'(o_err), 32'd1);
        chk({tag, "_busy_low"}, 32'(o_busy), 32'd0);
        @(negedge clk);
        chk({tag, "_err_clear"}, 32'(o_err), 32'd0);
        repeat (quiet) begin
            @(negedge clk);
            if (!o_uart_tx) lows++;
            if (o_busy) busys++;
        end
        chk({tag, "_tx_low_cycles"}, 32'(lows), 32'd0);
        chk({tag, "_busy_cycles"}, 32'(busys), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt - e0), 32'd1);
        chk({tag, "_no_done"}, 32'(done_cnt - d0), 32'd0);
    endtask

    initial begin
        int w;
        int lows;
        int busys;
        int d0;
        int e0;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        mem[9'h010] = 32'd1;     mem[9'h011] = 32'd2;   mem[9'h012] = 32'd3;
        mem[9'h013] = 32'd40;    mem[9'h014] = 32'd500; mem[9'h015] = 32'd65535;
        mem[9'h020] = 32'h0001_0000;
        mem[9'h1FE] = 32'd7;     mem[9'h1FF] = 32'd8;   mem[9'h000] = 32'd9;
        mem[9'h001] = 32'd10;    mem[9'h002] = 32'd0;

        // Reset wins over a coincident start.
        rst = 1'b1; i_start = 1'b1; i_base_addr = 9'h010; i_m = 32'd2; i_n = 32'd3;
        @(posedge clk); #1; i_start = 1'b0;
        @(negedge clk);
        chk("rst_tx", 32'(o_uart_tx), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_addr", 32'(o_rd_addr), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_start_dropped", 32'(o_busy), 32'd0);

        exp_q.delete();
        exp_add("1 2 3"); exp_eol(); exp_add("40 500 65535"); exp_eol();
        run_xfer("m2x3", 9'h010, 2, 3, 1'b1, 9'h015);

        exp_q.delete();
        exp_add("0"); exp_eol();
        run_xfer("m1x1_hi", 9'h020, 1, 1, 1'b0, 9'h020);

        exp_q.delete();
        exp_add("7 8 9 10 0"); exp_eol();
        run_xfer("wrap1x5", 9'h1FE, 1, 5, 1'b0, 9'h002);

        run_err("m0", 0, 3, 1000);
        run_err("m6", 6, 1, 50);
        run_err("n6", 1, 6, 50);

        // Abort during the third data bit of the second byte.
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = 9'h010; i_m = 32'd2; i_n = 32'd3;
        @(posedge clk); #1; i_start = 1'b0;
        rx_q.delete(); st_q.delete(); bad_q.delete();
        w = 0;
        while (!(rx_q.size() == 1 && rx_phase >= 34) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reached", 32'(w < 3000), 32'd1);
        d0 = done_cnt; e0 = err_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", 32'(o_uart_tx), 32'd1);
        chk("abort_busy", 32'(o_busy), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        lows = 0; busys = 0;
        repeat (300) begin
            @(negedge clk);
            if (!o_uart_tx) lows++;
            if (o_busy) busys++;
        end
        chk("abort_quiet_tx", 32'(lows), 32'd0);
        chk("abort_quiet_busy", 32'(busys), 32'd0);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_no_err", 32'(err_cnt - e0), 32'd0);

        exp_q.delete();
        exp_add("1 2 3"); exp_eol(); exp_add("40 500 65535"); exp_eol();
        run_xfer("after_abort", 9'h010, 2, 3, 1'b0, 9'h015);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
